// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and helpers for the N:1 pipelined selector
package mux_pkg;

  localparam int   ERRCNT_W         = 16;
  localparam logic DEFAULT_ALL_ONES = 1'b1;

  // Smallest r with 2**r >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_pipe_stage.sv
// rtl/mux_pipe_stage.sv - one valid/data/err register slot of the output pipeline
module mux_pipe_stage import mux_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             advance_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             err_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             err_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;

  // Payload only moves with a real word so Out/Sel_Err keep the last word across bubbles.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    err_d   = err_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (advance_i) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d = data_i;
        err_d  = err_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign err_o   = err_q;

endmodule

// File: rtl/mux_n_pipe.sv
// rtl/mux_n_pipe.sv - N:1 operand/forwarding selector with valid/ready output pipeline
module mux_n_pipe import mux_pkg::*; #(
  parameter int               WIDTH       = 32,
  parameter int               NUM_IN      = 4,
  parameter int               SEL_W       = 4,
  parameter int               STAGES      = 1,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = {WIDTH{DEFAULT_ALL_ONES}}
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NUM_IN*WIDTH-1:0] In_Bus,
  input  logic [SEL_W-1:0]        SEL,
  input  logic                    In_Valid,
  output logic                    In_Ready,
  input  logic                    FLUSH,
  output logic [WIDTH-1:0]        Out,
  output logic                    Out_Valid,
  input  logic                    Out_Ready,
  output logic                    Sel_Err,
  output logic [ERRCNT_W-1:0]     Err_Count
);

  localparam int IDX_W = (clog2(NUM_IN) < 1) ? 1 : clog2(NUM_IN);
  localparam int SLOTS = 1 << IDX_W;

  // Inputs padded to a power of two so the index never runs off the bus.
  logic [WIDTH-1:0] slot [SLOTS];
  for (genvar k = 0; k < SLOTS; k++) begin : g_slot
    if (k < NUM_IN) begin : g_in
      assign slot[k] = In_Bus[k*WIDTH +: WIDTH];
    end else begin : g_def
      assign slot[k] = DEFAULT_VAL;
    end
  end

  logic             sel_ok;
  logic [WIDTH-1:0] sel_data;
  assign sel_ok   = 32'(SEL) < 32'(NUM_IN);
  assign sel_data = sel_ok ? slot[SEL[IDX_W-1:0]] : DEFAULT_VAL;

  logic [STAGES:0]  adv;
  logic [STAGES:0]  vld;
  logic [STAGES:0]  err;
  logic [WIDTH-1:0] dat [STAGES+1];

  // Advance ripples back from the consumer; In_Ready has no skid buffer behind it.
  always_comb begin
    adv         = '0;
    adv[STAGES] = Out_Ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      adv[i] = ~vld[i+1] | adv[i+1];
    end
  end

  assign In_Ready = adv[0] & ~FLUSH & ~RST;
  assign vld[0]   = In_Valid & In_Ready;
  assign dat[0]   = sel_data;
  assign err[0]   = ~sel_ok;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    mux_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk_i     (CLK),
      .rst_i     (RST),
      .flush_i   (FLUSH),
      .advance_i (adv[i]),
      .valid_i   (vld[i]),
      .data_i    (dat[i]),
      .err_i     (err[i]),
      .valid_o   (vld[i+1]),
      .data_o    (dat[i+1]),
      .err_o     (err[i+1])
    );
  end

  assign Out       = dat[STAGES];
  assign Out_Valid = vld[STAGES];
  assign Sel_Err   = err[STAGES];

  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  // Counted at acceptance, so flushed words stay counted.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (vld[0] && !sel_ok && (err_cnt_q != {ERRCNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERRCNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign Err_Count = err_cnt_q;

endmodule

// File: tb/tb_mux_n_pipe.sv
// tb/tb_mux_n_pipe.sv - directed self-checking bench for mux_n_pipe
module tb_mux_n_pipe;

  logic         clk;
  logic         rst;
  logic [159:0] bus5;
  logic [3:0]   sel4;

  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_sel_err;
  logic [31:0] a_out;
  logic [15:0] a_err_count;
  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_sel_err;
  logic [31:0] b_out;
  logic [15:0] b_err_count;
  logic        c_in_valid, c_in_ready, c_flush, c_out_valid, c_out_ready, c_sel_err;
  logic [31:0] c_out;
  logic [15:0] c_err_count;

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux_n_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_W(4), .STAGES(1)) u_a (
    .CLK(clk), .RST(rst), .In_Bus(bus5[127:0]), .SEL(sel4),
    .In_Valid(a_in_valid), .In_Ready(a_in_ready), .FLUSH(a_flush),
    .Out(a_out), .Out_Valid(a_out_valid), .Out_Ready(a_out_ready),
    .Sel_Err(a_sel_err), .Err_Count(a_err_count)
  );

  mux_n_pipe #(.WIDTH(32), .NUM_IN(5), .SEL_W(3), .STAGES(3)) u_b (
    .CLK(clk), .RST(rst), .In_Bus(bus5), .SEL(sel4[2:0]),
    .In_Valid(b_in_valid), .In_Ready(b_in_ready), .FLUSH(b_flush),
    .Out(b_out), .Out_Valid(b_out_valid), .Out_Ready(b_out_ready),
    .Sel_Err(b_sel_err), .Err_Count(b_err_count)
  );

  mux_n_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .STAGES(2)) u_c (
    .CLK(clk), .RST(rst), .In_Bus(bus5[95:0]), .SEL(sel4[1:0]),
    .In_Valid(c_in_valid), .In_Ready(c_in_ready), .FLUSH(c_flush),
    .Out(c_out), .Out_Valid(c_out_valid), .Out_Ready(c_out_ready),
    .Sel_Err(c_sel_err), .Err_Count(c_err_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int nacc;
  int nout;

  initial begin
    rst = 1'b1;
    sel4 = 4'd0;
    for (int k = 0; k < 5; k++) bus5[k*32 +: 32] = 32'(k) * 32'h11111111;
    a_in_valid = 1'b1; a_flush = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_flush = 1'b0; c_out_ready = 1'b1;
    #1;
    check("rst_in_ready", 32'(a_in_ready), 32'd0);
    tick();
    check("rst_a_out", a_out, 32'h0);
    check("rst_a_valid", 32'(a_out_valid), 32'd0);
    check("rst_a_cnt", 32'(a_err_count), 32'd0);
    check("rst_b_valid", 32'(b_out_valid), 32'd0);
    check("rst_b_cnt", 32'(b_err_count), 32'd0);
    check("rst_c_out", c_out, 32'h0);
    check("rst_c_valid", 32'(c_out_valid), 32'd0);
    rst = 1'b0;

    // 4:1, one stage, back to back
    for (int k = 0; k < 4; k++) begin
      sel4 = 4'(k);
      a_in_valid = 1'b1;
      tick();
      check("a_data", a_out, 32'(k) * 32'h11111111);
      check("a_valid", 32'(a_out_valid), 32'd1);
      check("a_sel_err", 32'(a_sel_err), 32'd0);
    end
    sel4 = 4'd9;
    tick();
    check("a_oor_data", a_out, 32'hFFFFFFFF);
    check("a_oor_err", 32'(a_sel_err), 32'd1);
    check("a_oor_cnt", 32'(a_err_count), 32'd1);
    a_in_valid = 1'b0;
    tick();
    check("a_bubble", 32'(a_out_valid), 32'd0);

    // 5:1, three stages, out-of-range selects
    sel4 = 4'd6; b_in_valid = 1'b1;
    tick();
    check("b_cnt_accept", 32'(b_err_count), 32'd1);
    check("b_lat_1", 32'(b_out_valid), 32'd0);
    sel4 = 4'd4;
    tick();
    check("b_lat_2", 32'(b_out_valid), 32'd0);
    sel4 = 4'd5;
    tick();
    check("b_w0_data", b_out, 32'hFFFFFFFF);
    check("b_w0_valid", 32'(b_out_valid), 32'd1);
    check("b_w0_err", 32'(b_sel_err), 32'd1);
    check("b_cnt_2", 32'(b_err_count), 32'd2);
    b_in_valid = 1'b0;
    tick();
    check("b_w1_data", b_out, 32'h44444444);
    check("b_w1_err", 32'(b_sel_err), 32'd0);
    tick();
    check("b_w2_data", b_out, 32'hFFFFFFFF);
    check("b_w2_err", 32'(b_sel_err), 32'd1);
    tick();
    check("b_drained", 32'(b_out_valid), 32'd0);

    sel4 = 4'd7; b_in_valid = 1'b1;
    repeat (65532) tick();
    check("b_cnt_fffe", 32'(b_err_count), 32'h0000FFFE);
    tick();
    check("b_cnt_ffff", 32'(b_err_count), 32'h0000FFFF);
    repeat (5) tick();
    check("b_cnt_sat", 32'(b_err_count), 32'h0000FFFF);
    b_in_valid = 1'b0;
    repeat (4) tick();
    check("b_empty", 32'(b_out_valid), 32'd0);

    // backpressure: full pipe holds exactly STAGES words
    b_out_ready = 1'b0;
    nacc = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      b_in_valid = 1'b1;
      sel4 = 4'(nacc + 1);
      #1;
      if (b_in_ready) nacc++;
      tick();
    end
    check("stall_accepted", 32'(nacc), 32'd3);
    check("stall_in_ready", 32'(b_in_ready), 32'd0);
    check("stall_hold_data", b_out, 32'h11111111);
    check("stall_hold_valid", 32'(b_out_valid), 32'd1);
    b_out_ready = 1'b1;
    nout = 0;
    for (int cyc = 0; cyc < 16 && nout < 4; cyc++) begin
      b_in_valid = (nacc < 4);
      sel4 = 4'(nacc + 1);
      #1;
      if (b_out_valid) begin
        check("stall_order", b_out, 32'(nout + 1) * 32'h11111111);
        nout++;
      end
      if (b_in_valid && b_in_ready) nacc++;
      tick();
    end
    b_in_valid = 1'b0;
    check("stall_delivered", 32'(nout), 32'd4);

    // flush on a full, stalled pipe
    c_out_ready = 1'b0; c_in_valid = 1'b1; sel4 = 4'd3;
    tick();
    sel4 = 4'd2;
    tick();
    check("c_full_data", c_out, 32'hFFFFFFFF);
    check("c_full_err", 32'(c_sel_err), 32'd1);
    check("c_full_ready", 32'(c_in_ready), 32'd0);
    check("c_cnt_pre", 32'(c_err_count), 32'd1);
    c_out_ready = 1'b1; c_flush = 1'b1; sel4 = 4'd3;
    #1;
    check("flush_in_ready", 32'(c_in_ready), 32'd0);
    tick();
    check("flush_valid", 32'(c_out_valid), 32'd0);
    check("flush_cnt", 32'(c_err_count), 32'd1);
    c_flush = 1'b0; c_in_valid = 1'b0;
    tick();
    check("flush_no_accept", 32'(c_out_valid), 32'd0);

    // reset with two words in flight
    c_in_valid = 1'b1; sel4 = 4'd1;
    tick();
    sel4 = 4'd2;
    tick();
    check("c_lat2_data", c_out, 32'h11111111);
    check("c_lat2_valid", 32'(c_out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_c_in_ready", 32'(c_in_ready), 32'd0);
    tick();
    check("rst2_c_out", c_out, 32'h0);
    check("rst2_c_valid", 32'(c_out_valid), 32'd0);
    check("rst2_c_cnt", 32'(c_err_count), 32'd0);
    check("rst2_c_err", 32'(c_sel_err), 32'd0);
    check("rst2_b_cnt", 32'(b_err_count), 32'd0);
    rst = 1'b0; sel4 = 4'd1;
    tick();
    c_in_valid = 1'b0;
    check("post_rst_lat1", 32'(c_out_valid), 32'd0);
    tick();
    check("post_rst_data", c_out, 32'h11111111);
    check("post_rst_valid", 32'(c_out_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=expired expected=finish");
    $fatal(1);
  end

endmodule
